// File: rtl/layer_mem_arbiter_pkg.sv
// Shared constants and types for the layer-memory arbiter slice.
package conv_pkg;

  localparam int AW = 12;
  localparam int DW = 20;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_L0_K0 = 3'd1;
  localparam logic [2:0] SEL_L0_K1 = 3'd2;
  localparam logic [2:0] SEL_L1_K0 = 3'd3;
  localparam logic [2:0] SEL_L1_K1 = 3'd4;
  localparam logic [2:0] SEL_L2    = 3'd5;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} own_state_t;

endpackage

// File: rtl/layer_mem_arbiter_if.sv
// Engine and layer-memory signals of the arbiter; slave = arbiter side, master = engines plus memory.
interface layer_mem_arbiter_if #(
  parameter int AW = conv_pkg::AW,
  parameter int DW = conv_pkg::DW
);
  logic          req0, req1;
  logic          lock0, lock1;
  logic          we0, we1;
  logic [2:0]    sel0, sel1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic [2:0]    csel;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, sel0, sel1,
           addr0, addr1, wdata0, wdata1, cdata_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata,
           csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, sel0, sel1,
           addr0, addr1, wdata0, wdata1, cdata_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata,
           csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd
  );
endinterface

// File: rtl/layer_mem_arbiter_fsm.sv
// Round-robin ownership FSM: owner state, last owner and locked-burst beat counter.
module rr_owner_fsm
  import conv_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

  own_state_t state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [3:0] beat_cnt, beat_cnt_nxt;
  logic       own1, req_i, req_j, lock_i, rel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Requester i is the current owner, j the other side.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    own1   = (state == OWN1);
    req_i  = own1 ? req1 : req0;
    req_j  = own1 ? req0 : req1;
    lock_i = own1 ? lock1 : lock0;
    rel    = 1'b0;
    case (state)
      IDLE: begin
        beat_cnt_nxt = '0;
        if (req0 && req1)  state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)     state_nxt = OWN0;
        else if (req1)     state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        rel = !req_i || !lock_i || ((beat_cnt == CNT_MAX) && req_j);
        if (rel) begin
          last_owner_nxt = own1;
          beat_cnt_nxt   = '0;
          if (req_j)                state_nxt = own1 ? OWN0 : OWN1;
          else if (req_i && !lock_i) state_nxt = state;
          else                      state_nxt = IDLE;
        end else if (beat_cnt != CNT_MAX) begin
          beat_cnt_nxt = beat_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);

endmodule

// File: rtl/layer_mem_arbiter.sv
// Arbitrates the single layer-memory port between the conv engine (0) and pool/flatten engine (1).
module layer_mem_arbiter #(
  parameter int AW        = conv_pkg::AW,
  parameter int DW        = conv_pkg::DW,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                reset,
  layer_mem_arbiter_if.slave  bus
);
  import conv_pkg::*;

  logic          gnt0, gnt1;
  logic          acc0, acc1, acc, beat_we;
  logic [2:0]    beat_sel;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;

  logic          cwr_q, crd_q;
  logic [2:0]    csel_q;
  logic [AW-1:0] caddr_wr_q, caddr_rd_q;
  logic [DW-1:0] cdata_wr_q, rdata_q;
  logic          tag1_vld, tag1_id, tag2_vld, tag2_id;
  logic          rvalid0_q, rvalid1_q;

  rr_owner_fsm #(.MAX_BURST(MAX_BURST)) u_owner_fsm (
    .clk   (clk),
    .reset (reset),
    .req0  (bus.req0),
    .req1  (bus.req1),
    .lock0 (bus.lock0),
    .lock1 (bus.lock1),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign acc0       = bus.req0 & gnt0;
  assign acc1       = bus.req1 & gnt1;
  assign acc        = acc0 | acc1;
  assign beat_we    = acc1 ? bus.we1    : bus.we0;
  assign beat_sel   = acc1 ? bus.sel1   : bus.sel0;
  assign beat_addr  = acc1 ? bus.addr1  : bus.addr0;
  assign beat_wdata = acc1 ? bus.wdata1 : bus.wdata0;

  // Accepted beat goes out one cycle later; the tag pipe follows a read until its data returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      csel_q     <= SEL_NONE;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      tag1_vld   <= 1'b0;
      tag1_id    <= 1'b0;
      tag2_vld   <= 1'b0;
      tag2_id    <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      cwr_q    <= acc & beat_we;
      crd_q    <= acc & !beat_we;
      tag1_vld <= acc & !beat_we;
      tag1_id  <= acc1;
      tag2_vld <= tag1_vld;
      tag2_id  <= tag1_id;
      if (acc) begin
        csel_q <= beat_sel;
        if (beat_we) begin
          caddr_wr_q <= beat_addr;
          cdata_wr_q <= beat_wdata;
        end else begin
          caddr_rd_q <= beat_addr;
        end
      end
      rvalid0_q <= tag2_vld & !tag2_id;
      rvalid1_q <= tag2_vld & tag2_id;
      if (tag2_vld) rdata_q <= bus.cdata_rd;
    end
  end

  assign bus.gnt0     = gnt0;
  assign bus.gnt1     = gnt1;
  assign bus.cwr      = cwr_q;
  assign bus.crd      = crd_q;
  assign bus.csel     = csel_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_layer_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an ownership/transaction model.
module tb_layer_mem_arbiter;
  import conv_pkg::*;

  localparam int MAXB = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  layer_mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  function automatic logic [DW-1:0] init_val(input logic [14:0] k);
    return {k[4:0], k} ^ 20'h5A5A5;
  endfunction

  // Layer memory owned by the bench: write on cwr, read data the cycle after crd.
  logic [DW-1:0] mem [logic [14:0]];
  always @(posedge clk) begin
    if (bus.crd)
      bus.cdata_rd <= mem.exists({bus.csel, bus.caddr_rd}) ? mem[{bus.csel, bus.caddr_rd}]
                                                           : init_val({bus.csel, bus.caddr_rd});
    if (bus.cwr) mem[{bus.csel, bus.caddr_wr}] = bus.cdata_wr;
  end

  // Reference model: who owns the port, pending read returns and the expected memory contents.
  typedef struct {int who; logic [DW-1:0] data; int due;} rd_t;
  rd_t           pend[$];
  logic [DW-1:0] shadow [logic [14:0]];
  int            owner = -1, last = 1, burst = 0, cyc = 0;
  bit            model_ok = 0;
  logic          exp_cwr, exp_crd;
  logic [2:0]    exp_csel;
  logic [AW-1:0] exp_aw, exp_ar;
  logic [DW-1:0] exp_dw;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input int who, input bit req, input bit lock, input bit we,
                               input logic [2:0] sel, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (who == 0) begin
      bus.req0 = req; bus.lock0 = lock; bus.we0 = we; bus.sel0 = sel; bus.addr0 = addr; bus.wdata0 = wdata;
    end else begin
      bus.req1 = req; bus.lock1 = lock; bus.we1 = we; bus.sel1 = sel; bus.addr1 = addr; bus.wdata1 = wdata;
    end
  endtask

  task automatic idle_all();
    applyStimulus(0, 0, 0, 0, 3'd0, '0, '0);
    applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
  endtask

  task automatic preload(input logic [14:0] k, input logic [DW-1:0] v);
    mem[k]    = v;
    shadow[k] = v;
  endtask

  task automatic check_model();
    bit v0, v1;
    logic [DW-1:0] d;
    v0 = 0; v1 = 0; d = '0;
    if (!model_ok) return;
    foreach (pend[n]) if (pend[n].due == cyc) begin
      if (pend[n].who == 0) v0 = 1; else v1 = 1;
      d = pend[n].data;
    end
    checkOutput("gnt0",     32'(bus.gnt0),     32'(owner == 0));
    checkOutput("gnt1",     32'(bus.gnt1),     32'(owner == 1));
    checkOutput("cwr",      32'(bus.cwr),      32'(exp_cwr));
    checkOutput("crd",      32'(bus.crd),      32'(exp_crd));
    checkOutput("csel",     32'(bus.csel),     32'(exp_csel));
    checkOutput("caddr_wr", 32'(bus.caddr_wr), 32'(exp_aw));
    checkOutput("cdata_wr", 32'(bus.cdata_wr), 32'(exp_dw));
    checkOutput("caddr_rd", 32'(bus.caddr_rd), 32'(exp_ar));
    checkOutput("rvalid0",  32'(bus.rvalid0),  32'(v0));
    checkOutput("rvalid1",  32'(bus.rvalid1),  32'(v1));
    if (v0 || v1) checkOutput("rdata", 32'(bus.rdata), 32'(d));
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
  endtask

  task automatic model_step();
    bit rq[2], lk[2], wev[2], acc, rel;
    logic [2:0] sv[2];
    logic [AW-1:0] av[2];
    logic [DW-1:0] dv[2];
    logic [14:0] k;
    int i, j;
    if (reset) begin
      owner = -1; last = 1; burst = 0;
      exp_cwr = 0; exp_crd = 0; exp_csel = '0; exp_aw = '0; exp_ar = '0; exp_dw = '0;
      pend.delete();
      model_ok = 1;
    end else if (model_ok) begin
      rq[0] = bus.req0;  rq[1] = bus.req1;  lk[0] = bus.lock0; lk[1] = bus.lock1;
      wev[0] = bus.we0;  wev[1] = bus.we1;  sv[0] = bus.sel0;  sv[1] = bus.sel1;
      av[0] = bus.addr0; av[1] = bus.addr1; dv[0] = bus.wdata0; dv[1] = bus.wdata1;
      acc = (owner >= 0) && rq[owner];
      exp_cwr = 0; exp_crd = 0;
      if (acc) begin
        k = {sv[owner], av[owner]};
        exp_csel = sv[owner];
        if (wev[owner]) begin
          exp_cwr = 1; exp_aw = av[owner]; exp_dw = dv[owner];
          shadow[k] = dv[owner];
        end else begin
          exp_crd = 1; exp_ar = av[owner];
          pend.push_back('{owner, shadow.exists(k) ? shadow[k] : init_val(k), cyc + 3});
        end
      end
      if (owner < 0) begin
        burst = 0;
        if (rq[0] && rq[1]) owner = (last == 0) ? 1 : 0;
        else if (rq[0])     owner = 0;
        else if (rq[1])     owner = 1;
      end else begin
        i = owner; j = 1 - owner;
        if (acc) burst++;
        rel = !acc || !lk[i] || (burst >= MAXB && rq[j]);
        if (rel) begin
          last = i; burst = 0;
          if (rq[j])              owner = j;
          else if (acc && !lk[i]) owner = i;
          else                    owner = -1;
        end
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string p);
    checkOutput({p, "_gnt0"},     32'(bus.gnt0),     0);
    checkOutput({p, "_gnt1"},     32'(bus.gnt1),     0);
    checkOutput({p, "_cwr"},      32'(bus.cwr),      0);
    checkOutput({p, "_crd"},      32'(bus.crd),      0);
    checkOutput({p, "_csel"},     32'(bus.csel),     0);
    checkOutput({p, "_caddr_wr"}, 32'(bus.caddr_wr), 0);
    checkOutput({p, "_caddr_rd"}, 32'(bus.caddr_rd), 0);
    checkOutput({p, "_cdata_wr"}, 32'(bus.cdata_wr), 0);
    checkOutput({p, "_rvalid0"},  32'(bus.rvalid0),  0);
    checkOutput({p, "_rvalid1"},  32'(bus.rvalid1),  0);
    checkOutput({p, "_rdata"},    32'(bus.rdata),    0);
  endtask

  initial begin
    int beats0, gaps;
    bit seen1, started;
    reset = 1'b1;
    idle_all();
    #1;
    step(); step();
    reset = 1'b0;
    check_all_zero("reset_state");

    $display("[TB] reset in the middle of a read");
    applyStimulus(0, 1, 0, 0, SEL_L0_K0, 12'h041, '0); step();
    step();
    idle_all(); reset = 1'b1; step();
    reset = 1'b0;
    check_all_zero("rst_mid_read");
    for (int n = 0; n < 4; n++) begin
      step();
      checkOutput("rst_mid_read_rvalid0", 32'(bus.rvalid0), 0);
    end

    $display("[TB] single write");
    applyStimulus(0, 1, 0, 1, SEL_L0_K0, 12'h0A5, 20'h01310); step();
    checkOutput("single_gnt0", 32'(bus.gnt0), 1);
    step();
    idle_all();
    checkOutput("single_cwr",      32'(bus.cwr),      1);
    checkOutput("single_csel",     32'(bus.csel),     1);
    checkOutput("single_caddr_wr", 32'(bus.caddr_wr), 32'h0A5);
    checkOutput("single_cdata_wr", 32'(bus.cdata_wr), 32'h01310);
    step();
    checkOutput("single_idle_gnt0", 32'(bus.gnt0), 0);
    checkOutput("single_idle_gnt1", 32'(bus.gnt1), 0);
    step(); step();

    $display("[TB] tie-break from reset");
    reset = 1'b1; step();
    reset = 1'b0;
    applyStimulus(0, 1, 0, 1, SEL_L0_K1, 12'h001, 20'h00011);
    applyStimulus(1, 1, 0, 1, SEL_L1_K0, 12'h002, 20'h00022);
    step();
    checkOutput("tie_first_gnt0", 32'(bus.gnt0), 1);
    checkOutput("tie_first_gnt1", 32'(bus.gnt1), 0);
    step();
    idle_all();
    checkOutput("tie_next_gnt1", 32'(bus.gnt1), 1);
    step(); step(); step();

    $display("[TB] locked burst with contention");
    beats0 = 0; seen1 = 0;
    for (int n = 0; n < 60 && !seen1; n++) begin
      if (bus.gnt1) seen1 = 1;
      else begin
        applyStimulus(0, 1, 1, 1, SEL_L0_K0, 12'(n), 20'($urandom));
        applyStimulus(1, beats0 >= 2, 0, 1, SEL_L1_K1, 12'h100, 20'h0BEEF);
        if (bus.gnt0) beats0++;
        step();
      end
    end
    checkOutput("burst_handover_seen",  32'(seen1),  1);
    checkOutput("burst_handover_beats", 32'(beats0), MAXB);
    idle_all();
    step(); step(); step();

    $display("[TB] locked burst without contention");
    beats0 = 0; gaps = 0; seen1 = 0; started = 0;
    for (int n = 0; n < 40 && beats0 < 20; n++) begin
      applyStimulus(0, 1, beats0 < 19, 1, SEL_L0_K1, 12'(n + 16), 20'($urandom));
      applyStimulus(1, 0, 0, 0, 3'd0, '0, '0);
      if (bus.gnt1) seen1 = 1;
      if (bus.gnt0) begin beats0++; started = 1; end
      else if (started) gaps++;
      step();
    end
    checkOutput("solo_burst_beats", 32'(beats0), 20);
    checkOutput("solo_burst_gaps",  32'(gaps),   0);
    checkOutput("solo_burst_gnt1",  32'(seen1),  0);
    idle_all();
    step(); step(); step();

    $display("[TB] read return across an ownership switch");
    preload({SEL_L1_K0, 12'h010}, 20'h00ABC);
    applyStimulus(1, 1, 0, 0, SEL_L1_K0, 12'h010, '0); step();
    checkOutput("xsw_gnt1", 32'(bus.gnt1), 1);
    applyStimulus(0, 1, 0, 1, SEL_L0_K0, 12'h020, 20'h00555);
    step();
    idle_all();
    checkOutput("xsw_gnt0", 32'(bus.gnt0), 1);
    step(); step();
    checkOutput("xsw_rvalid1", 32'(bus.rvalid1), 1);
    checkOutput("xsw_rdata",   32'(bus.rdata),   32'h00ABC);
    checkOutput("xsw_rvalid0", 32'(bus.rvalid0), 0);
    step(); step();

    $display("[TB] write then read, same location");
    applyStimulus(0, 1, 1, 1, SEL_L2, 12'h7FF, 20'h12345); step();
    step();
    applyStimulus(0, 1, 0, 0, SEL_L2, 12'h7FF, '0); step();
    idle_all(); step(); step();
    checkOutput("wtr_rvalid0", 32'(bus.rvalid0), 1);
    checkOutput("wtr_rdata",   32'(bus.rdata),   32'h12345);
    step(); step();

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int w = 0; w < 2; w++)
        applyStimulus(w, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                      3'($urandom_range(0, 5)), 12'($urandom_range(0, 7)), 20'($urandom));
      step();
    end
    reset = 1'b0;
    idle_all();
    for (int n = 0; n < 6; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
